nibble_serial_adder: RTL and testbench

//  Multi-cycle adder that is the additive counterpart of the 4-bit subtractor.

---
 rtl/arith_pkg.sv | 13 +
 rtl/adder_4bit_slice.sv | 14 +
 rtl/nibble_serial_adder.sv | 138 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: controller state encoding and slice width.
// Reused by the serial adder and the subtractor family.
package arith_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arithState_t;

endpackage

// File: rtl/adder_4bit_slice.sv
// Combinational 4-bit slice adder: {c_o, s_o} = x_i + y_i + cin_i.
module adder_4bit_slice
  import arith_pkg::*;
(
  input  logic [SLICE_W-1:0] x_i,
  input  logic [SLICE_W-1:0] y_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               c_o
);

  assign {c_o, s_o} = {1'b0, x_i} + {1'b0, y_i} + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit slice per clock, LSB slice first, start/done handshake.
// Optional OVERFLOW_FLAG_EN adds a registered two's-complement overflow output.
module nibble_serial_adder
  import arith_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       carry_out
`ifdef OVERFLOW_FLAG_EN
  ,output logic                      overflow
`endif
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  arithState_t        state_q, state_d;
  logic [W-1:0]       opA_q, opA_d;
  logic [W-1:0]       opB_q, opB_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   sliceIdx_q, sliceIdx_d;
  logic               done_q, done_d;
  logic               carryOut_q, carryOut_d;
`ifdef OVERFLOW_FLAG_EN
  logic               ovfPending_q, ovfPending_d;
  logic               overflow_q, overflow_d;
`endif

  logic [SLICE_W-1:0] sliceA, sliceB, sliceSum;
  logic               sliceCarry;

  assign sliceA = opA_q[SLICE_W*int'(sliceIdx_q) +: SLICE_W];
  assign sliceB = opB_q[SLICE_W*int'(sliceIdx_q) +: SLICE_W];

  adder_4bit_slice u_slice (
    .x_i  (sliceA),
    .y_i  (sliceB),
    .cin_i(carry_q),
    .s_o  (sliceSum),
    .c_o  (sliceCarry)
  );

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    sliceIdx_d = sliceIdx_q;
    done_d     = 1'b0;
    carryOut_d = carryOut_q;
`ifdef OVERFLOW_FLAG_EN
    ovfPending_d = ovfPending_q;
    overflow_d   = overflow_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opA_d      = a;
          opB_d      = b;
          carry_d    = 1'b0;
          sliceIdx_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        sum_d[SLICE_W*int'(sliceIdx_q) +: SLICE_W] = sliceSum;
        carry_d    = sliceCarry;
        sliceIdx_d = sliceIdx_q + IDX_W'(1);
        if (sliceIdx_q == LAST_IDX) begin
          state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
          // Carry into the MSB is recovered from the MSB's own sum bit.
          ovfPending_d = sliceCarry ^ (sliceA[SLICE_W-1] ^ sliceB[SLICE_W-1] ^ sliceSum[SLICE_W-1]);
`endif
        end
      end
      DONE: begin
        done_d     = 1'b1;
        carryOut_d = carry_q;
`ifdef OVERFLOW_FLAG_EN
        overflow_d = ovfPending_q;
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      sliceIdx_q <= '0;
      done_q     <= 1'b0;
      carryOut_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovfPending_q <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      sliceIdx_q <= sliceIdx_d;
      done_q     <= done_d;
      carryOut_q <= carryOut_d;
`ifdef OVERFLOW_FLAG_EN
      ovfPending_q <= ovfPending_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign busy      = (state_q == BUSY);
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carryOut_q;
`ifdef OVERFLOW_FLAG_EN
  assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: cycle model plus directed literal checks.
// Also exercises a NIBBLES=1 instance; overflow checks compile in with OVERFLOW_FLAG_EN.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;
  logic         start1 = 1'b0;
  logic [3:0]   a1 = '0, b1 = '0;
  logic         busy1, done1, carry1;
  logic [3:0]   sum1;
`ifdef OVERFLOW_FLAG_EN
  logic         overflow, overflow1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
`ifdef OVERFLOW_FLAG_EN
    ,.overflow(overflow)
`endif
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry1)
`ifdef OVERFLOW_FLAG_EN
    ,.overflow(overflow1)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Transaction-level model: one accepted operation at a time, result lands N+1 edges later.
  int           edgeNo = 0;
  int           acceptEdge = -1;
  int           nextAccept = 0;
  logic [W-1:0] pendSum, heldSum;
  logic         pendCarry, heldCarry, pendOvf, heldOvf;
  bit           expDone, expBusy, inFlight;

  always @(posedge clk) begin
    edgeNo++;
    if (rst) begin
      acceptEdge = -1;
      nextAccept = edgeNo + 1;
      heldSum    = '0;
      heldCarry  = 1'b0;
      heldOvf    = 1'b0;
    end else begin
      if (acceptEdge >= 0 && edgeNo == acceptEdge + N + 1) begin
        heldSum   = pendSum;
        heldCarry = pendCarry;
        heldOvf   = pendOvf;
      end
      if (start && edgeNo >= nextAccept) begin
        {pendCarry, pendSum} = {1'b0, a} + {1'b0, b};
        pendOvf    = (a[W-1] == b[W-1]) && (pendSum[W-1] != a[W-1]);
        acceptEdge = edgeNo;
        nextAccept = edgeNo + N + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (edgeNo > 0) begin
      expDone  = (acceptEdge >= 0) && (edgeNo == acceptEdge + N + 1);
      expBusy  = (acceptEdge >= 0) && (edgeNo >= acceptEdge) && (edgeNo <= acceptEdge + N - 1);
      inFlight = (acceptEdge >= 0) && (edgeNo >= acceptEdge) && (edgeNo <= acceptEdge + N);
      checkOutput("model done", 32'(done), 32'(expDone));
      checkOutput("model busy", 32'(busy), 32'(expBusy));
      if (!inFlight) begin
        checkOutput("model sum", 32'(sum), 32'(heldSum));
        checkOutput("model carry_out", 32'(carry_out), 32'(heldCarry));
`ifdef OVERFLOW_FLAG_EN
        checkOutput("model overflow", 32'(overflow), 32'(heldOvf));
`endif
      end
    end
  end

  // Pulse start for one edge, then count edges until done shows.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, output int offset);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv;
    offset = 0;
    while (!done && offset < 20) begin
      @(negedge clk);
      offset++;
    end
  endtask

  int off, cnt, firstDone, secondDone;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset carry_out", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // NIBBLES=1 instance: F+1 wraps, done two edges after the start edge.
    @(negedge clk);
    a1 = 4'hF; b1 = 4'h1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    off = 0;
    while (!done1 && off < 20) begin
      @(negedge clk);
      off++;
    end
    checkOutput("n1 done offset", 32'(off), 32'd2);
    checkOutput("n1 sum", 32'(sum1), 32'h0);
    checkOutput("n1 carry_out", 32'(carry1), 32'd1);

    applyStimulus(16'h1234, 16'h4321, off);
    checkOutput("1234+4321 done offset", 32'(off), 32'd5);
    checkOutput("1234+4321 sum", 32'(sum), 32'h5555);
    checkOutput("1234+4321 carry_out", 32'(carry_out), 32'd0);

    applyStimulus(16'hFFFF, 16'h0001, off);
    checkOutput("FFFF+0001 sum", 32'(sum), 32'h0000);
    checkOutput("FFFF+0001 carry_out", 32'(carry_out), 32'd1);

    applyStimulus(16'h7FFF, 16'h0001, off);
    checkOutput("7FFF+0001 sum", 32'(sum), 32'h8000);
    checkOutput("7FFF+0001 carry_out", 32'(carry_out), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("7FFF+0001 overflow", 32'(overflow), 32'd1);
`endif

    applyStimulus(16'h8000, 16'h8000, off);
    checkOutput("8000+8000 sum", 32'(sum), 32'h0000);
    checkOutput("8000+8000 carry_out", 32'(carry_out), 32'd1);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("8000+8000 overflow", 32'(overflow), 32'd1);
`endif

    applyStimulus(16'h0001, 16'h0001, off);
    checkOutput("0001+0001 sum", 32'(sum), 32'h0002);
    checkOutput("0001+0001 carry_out", 32'(carry_out), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("0001+0001 overflow", 32'(overflow), 32'd0);
`endif

    // start held high while operands change every cycle: one done per N+2 cycles.
    @(negedge clk);
    start = 1'b1;
    cnt = 0; firstDone = -1; secondDone = -1;
    for (int i = 0; i < 18; i++) begin
      a = 16'(i * 16'h1111 + 16'h0F0F);
      b = 16'(i * 16'h0707 + 16'hE00E);
      @(negedge clk);
      if (done) begin
        cnt++;
        if (firstDone < 0) firstDone = i;
        else if (secondDone < 0) secondDone = i;
      end
    end
    start = 1'b0;
    checkOutput("held start done count", 32'(cnt), 32'd3);
    checkOutput("held start done interval", 32'(secondDone - firstDone), 32'd6);
    repeat (3) @(negedge clk);

    // Abort mid-operation after a result with carry_out=1 is held.
    applyStimulus(16'hFFFF, 16'h0001, off);
    checkOutput("pre-abort carry_out", 32'(carry_out), 32'd1);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort sum", 32'(sum), 32'd0);
    checkOutput("abort carry_out", 32'(carry_out), 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput("abort no done", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
